// File: rtl/jts16_dump_pkg.sv
// jts16_dump_pkg: shared constants and FSM state encoding for the S16 dump sequencer
package jts16_dump_pkg;
  localparam logic [1:0] SEL_VRAM = 2'd0, SEL_CHAR = 2'd1, SEL_PAL = 2'd2, SEL_OBJ = 2'd3;
  localparam int CHAR_W = 2048, PAL_W = 2048, OBJ_W = 1024;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HI, LO, DONE} state_t;
  function automatic int addr_w(input int vramw);
    return vramw > 11 ? vramw : 11;
  endfunction
endpackage

// File: rtl/jts16_dump_seq_if.sv
// jts16_dump_seq_if: video memory read port and byte sink stream of the dump sequencer
interface jts16_dump_seq_if #(parameter int AW = 14);
  logic          mem_rd, mem_ok, dump_pal, dump_obj, st_valid, st_ready;
  logic [1:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_dout;
  logic [16:0]   st_addr;
  logic [7:0]    st_data;
  modport master(
    output mem_rd, mem_sel, mem_addr, dump_pal, dump_obj, st_addr, st_data, st_valid,
    input  mem_ok, mem_dout, st_ready
  );
  modport slave(
    input  mem_rd, mem_sel, mem_addr, dump_pal, dump_obj, st_addr, st_data, st_valid,
    output mem_ok, mem_dout, st_ready
  );
endinterface

// File: rtl/jts16_dump_addr.sv
// jts16_dump_addr: dump map word pointer with region rollover and byte address generation
module jts16_dump_addr
  import jts16_dump_pkg::*;
#(
  parameter int VRAMW = 14,
  parameter int AW = addr_w(VRAMW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          next,
  output logic [2:0]    region,
  output logic [AW-1:0] word,
  output logic [16:0]   byte_addr,
  output logic          last
);
  localparam logic [16:0] VB = 17'(2 ** (VRAMW + 1));
  logic [AW-1:0] wmax;
  logic [16:0]   base;
  always_comb begin
    wmax = region == 3'(SEL_VRAM) ? AW'(2 ** VRAMW - 1) :
           region == 3'(SEL_OBJ)  ? AW'(OBJ_W - 1) :
           region == 3'(SEL_PAL)  ? AW'(PAL_W - 1) : AW'(CHAR_W - 1);
    base = region == 3'(SEL_VRAM) ? 17'd0 :
           region == 3'(SEL_CHAR) ? VB :
           region == 3'(SEL_PAL)  ? VB + 17'd4096 :
           region == 3'(SEL_OBJ)  ? VB + 17'd8192 : VB + 17'd10240;
  end
  assign byte_addr = base + 17'({word, 1'b0});
  assign last = region == 3'd4;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      region <= 3'd0;
      word   <= '0;
    end else if (next) begin
      region <= word == wmax ? region + 3'd1 : region;
      word   <= word == wmax ? '0 : word + AW'(1);
    end
  end
endmodule

// File: rtl/jts16_dump_seq.sv
// jts16_dump_seq: walks the S16 video-state dump map and streams it high byte first to the save sink
module jts16_dump_seq
  import jts16_dump_pkg::*;
#(
  parameter int VRAMW = 14,
  parameter int TMOW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             lvbl,
  input  logic [5:0]       tile_bank,
  jts16_dump_seq_if.master bus
);
  localparam int AW = addr_w(VRAMW);
  state_t          st;
  logic [7:0]      lo;
  logic [TMOW-1:0] tmo;
  logic [2:0]      region;
  logic [AW-1:0]   wptr;
  logic [16:0]     byte_addr;
  logic            last, clr, next, pal_obj;
  assign clr     = st == IDLE && start;
  assign next    = st == LO && bus.st_ready && !last;
  assign pal_obj = region == 3'(SEL_PAL) || region == 3'(SEL_OBJ);
  jts16_dump_addr #(.VRAMW(VRAMW), .AW(AW)) u_addr (
    .clk(clk), .rst(rst), .clr(clr), .next(next),
    .region(region), .word(wptr), .byte_addr(byte_addr), .last(last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      lo           <= 8'd0;
      tmo          <= '0;
      bus.mem_rd   <= 1'b0;
      bus.mem_sel  <= 2'd0;
      bus.mem_addr <= '0;
      bus.dump_pal <= 1'b0;
      bus.dump_obj <= 1'b0;
      bus.st_valid <= 1'b0;
      bus.st_addr  <= 17'd0;
      bus.st_data  <= 8'd0;
    end else begin
      case (st)
        IDLE: if (start) begin
          busy <= 1'b1;
          err  <= 1'b0;
          st   <= REQ;
        end
        REQ: if (last) begin
          lo           <= {2'b0, tile_bank};
          bus.st_data  <= 8'd0;
          bus.st_addr  <= byte_addr;
          bus.st_valid <= 1'b1;
          st           <= HI;
        end else if (!(pal_obj && lvbl)) begin
          bus.mem_rd   <= 1'b1;
          bus.mem_sel  <= region[1:0];
          bus.mem_addr <= wptr;
          bus.dump_pal <= region == 3'(SEL_PAL);
          bus.dump_obj <= region == 3'(SEL_OBJ);
          tmo          <= '0;
          st           <= WAIT;
        end
        WAIT: if (bus.mem_ok || &tmo) begin
          lo           <= bus.mem_ok ? bus.mem_dout[7:0] : 8'hFF;
          bus.st_data  <= bus.mem_ok ? bus.mem_dout[15:8] : 8'hFF;
          err          <= err | !bus.mem_ok;
          bus.mem_rd   <= 1'b0;
          bus.dump_pal <= 1'b0;
          bus.dump_obj <= 1'b0;
          bus.st_addr  <= byte_addr;
          bus.st_valid <= 1'b1;
          st           <= HI;
        end else begin
          tmo <= tmo + TMOW'(1);
        end
        HI: if (bus.st_ready) begin
          bus.st_data <= lo;
          bus.st_addr <= bus.st_addr | 17'd1;
          st          <= LO;
        end
        LO: if (bus.st_ready) begin
          bus.st_valid <= 1'b0;
          done         <= last;
          busy         <= !last;
          st           <= last ? DONE : REQ;
        end
        default: begin
          done <= 1'b0;
          st   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jts16_dump_seq.sv
// tb_jts16_dump_seq: randomized dump runs checked against a byte-map model of the dump
module tb_jts16_dump_seq;
  localparam int N = 32 + 10242;
  logic       clk, rst, start, busy, done, err, lvbl;
  logic [5:0] tile_bank;
  int  errors = 0, checks = 0;
  int  idx = 0, done_cnt = 0, pal_reads = 0, obj_reads = 0;
  bit  sup = 0, rmode = 0;
  jts16_dump_seq_if #(.AW(11)) bus();
  jts16_dump_seq #(.VRAMW(4), .TMOW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .lvbl(lvbl), .tile_bank(tile_bank), .bus(bus.master)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (byte %0d, t=%0t)", name, act, exp, idx, $time);
    end
  endtask
  function automatic logic [15:0] mem_word(input int sel, input int adr);
    logic [1:0] s;
    s = 2'(sel);
    return 16'(adr) ^ 16'hA5A5 ^ {s, 14'd0};
  endfunction
  // Dump map at VRAMW=4 in words: VRAM 0..15, CHAR 16..2063, PAL 2064..4111, OBJ 4112..5135, TBANK 5136
  function automatic logic [7:0] exp_byte(input int a, input logic [5:0] tb, input bit s);
    int off;
    logic [15:0] d;
    off = a / 2;
    if (off < 16) d = mem_word(0, off);
    else if (off < 2064) d = (s && off == 21) ? 16'hFFFF : mem_word(1, off - 16);
    else if (off < 4112) d = mem_word(2, off - 2064);
    else if (off < 5136) d = mem_word(3, off - 4112);
    else d = {10'd0, tb};
    return a % 2 == 1 ? d[7:0] : d[15:8];
  endfunction
  // Environment: sink ready, vertical blank, memory with 2-cycle read latency and stray mem_ok pulses
  initial begin
    int cyc, age, burst;
    cyc = 0; age = 0; burst = 0;
    bus.st_ready = 1'b1; bus.mem_ok = 1'b0; bus.mem_dout = 16'd0; lvbl = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.st_ready = rmode ? (cyc % 3 == 0) : 1'b1;
      if (burst > 0) burst--;
      else if ($urandom_range(0, 399) == 0) burst = 20;
      lvbl = burst > 0 ? 1'b1 : ($urandom_range(0, 3) == 0);
      bus.mem_ok = 1'b0;
      if (bus.mem_rd) begin
        age++;
        if (age == 2 && !(sup && bus.mem_sel == 2'd1 && bus.mem_addr == 11'd5)) begin
          bus.mem_ok = 1'b1;
          bus.mem_dout = mem_word(int'(bus.mem_sel), int'(bus.mem_addr));
        end
      end else begin
        age = 0;
        if ($urandom_range(0, 7) == 0) begin
          bus.mem_ok = 1'b1;
          bus.mem_dout = 16'($urandom);
        end
      end
    end
  end
  // Per-cycle comparison against the model
  initial begin
    bit prd, pok, pv, prdy, plv, pstall, stall;
    logic [1:0] psel;
    logic [10:0] padr;
    logic [16:0] pa;
    logic [7:0] pd;
    int hi_len;
    prd = 0; pok = 0; pv = 0; prdy = 0; plv = 0; pstall = 0; hi_len = 0;
    psel = 0; padr = 0; pa = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        idx = 0; prd = 0; pok = 0; pv = 0; prdy = 0; pstall = 0; hi_len = 0;
      end else begin
        check("dump_pal", bus.dump_pal, bus.mem_rd && bus.mem_sel == 2'd2);
        check("dump_obj", bus.dump_obj, bus.mem_rd && bus.mem_sel == 2'd3);
        if (bus.mem_rd && !prd && bus.mem_sel[1]) begin
          check("palobj_in_blank", plv, 0);
          if (bus.mem_sel == 2'd2) pal_reads++; else obj_reads++;
        end
        if (prd && pok) check("rd_drop_on_ok", bus.mem_rd, 0);
        if (!bus.mem_rd && prd && !pok) begin
          check("tmo_word", sup && psel == 2'd1 && padr == 11'd5, 1);
          check("tmo_len", hi_len >= 255 && hi_len <= 257, 1);
        end
        hi_len = bus.mem_rd ? hi_len + 1 : 0;
        stall = busy && !bus.mem_rd && !bus.st_valid && !done;
        if (pstall && !plv) check("req_latency", stall, 0);
        if (pv && !prdy) begin
          check("hold_valid", bus.st_valid, 1);
          check("hold_addr", bus.st_addr, pa);
          check("hold_data", bus.st_data, pd);
        end
        if (bus.st_valid && bus.st_ready) begin
          check("st_addr", bus.st_addr, idx);
          check("st_data", bus.st_data, exp_byte(idx, tile_bank, sup));
          check("err_flag", err, sup && idx >= 42);
          idx++;
        end
        if (done) begin
          done_cnt++;
          check("done_at_end", idx, N);
          check("busy_at_done", busy, 0);
        end
        prd = bus.mem_rd; pok = bus.mem_ok; pv = bus.st_valid; prdy = bus.st_ready;
        plv = lvbl; pstall = stall; psel = bus.mem_sel; padr = bus.mem_addr;
        pa = bus.st_addr; pd = bus.st_data;
      end
    end
  end
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin @(posedge clk); c++; end
    check("done_within_budget", done_cnt != 0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_mem_rd"}, bus.mem_rd, 0);
    check({tag, "_st_valid"}, bus.st_valid, 0);
    check({tag, "_dump_pal"}, bus.dump_pal, 0);
    check({tag, "_dump_obj"}, bus.dump_obj, 0);
    check({tag, "_st_addr"}, bus.st_addr, 0);
    check({tag, "_st_data"}, bus.st_data, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_sel"}, bus.mem_sel, 0);
  endtask
  initial begin
    int c;
    rst = 1'b1; start = 1'b0; tile_bank = 6'h2A; sup = 1; rmode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    check("model_b0", exp_byte(0, 6'h2A, 0), 8'hA5);
    check("model_b3", exp_byte(3, 6'h2A, 0), 8'hA4);
    check("model_char4_hi", exp_byte(40, 6'h2A, 0), 8'hE5);
    check("model_char5_lo", exp_byte(43, 6'h2A, 0), 8'hA0);
    check("model_tmo_byte", exp_byte(42, 6'h2A, 1), 8'hFF);
    check("model_pal0_hi", exp_byte(4128, 6'h2A, 0), 8'h25);
    check("model_obj_last_lo", exp_byte(10271, 6'h2A, 0), 8'h5A);
    check("model_tbank_hi", exp_byte(N - 2, 6'h2A, 0), 8'h00);
    check("model_tbank_lo", exp_byte(N - 1, 6'h2A, 0), 8'h2A);
    // Always-ready sink, CHAR word 5 never answered, stray start while busy
    idx = 0; done_cnt = 0; pal_reads = 0; obj_reads = 0;
    pulse_start();
    repeat (5) @(posedge clk);
    pulse_start();
    wait_done(60000);
    check("a_done_once", done_cnt, 1);
    check("a_bytes", idx, N);
    check("a_err_sticky", err, 1);
    check("a_pal_reads", pal_reads, 2048);
    check("a_obj_reads", obj_reads, 1024);
    check("a_idle_busy", busy, 0);
    // Slow sink, reset in the middle of VRAM
    sup = 0; rmode = 1; idx = 0; done_cnt = 0;
    pulse_start();
    c = 0;
    while (idx < 20 && c < 2000) begin @(posedge clk); c++; end
    check("b_reach_byte20", idx >= 20, 1);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    check("midrst_no_done", done_cnt, 0);
    // Full restart after the reset
    idx = 0; done_cnt = 0; pal_reads = 0; obj_reads = 0;
    pulse_start();
    wait_done(60000);
    check("c_done_once", done_cnt, 1);
    check("c_bytes", idx, N);
    check("c_err_clear", err, 0);
    check("c_pal_reads", pal_reads, 2048);
    check("c_obj_reads", obj_reads, 1024);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
